// File: rtl/ps2_cmd_sequencer.sv
// Command sequencer between system logic and the PS/2 controller: sends one byte,
// waits for ACK/resend/error, collects up to 3 responses, streams unsolicited bytes.
module ps2_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd_byte,
  input  logic [1:0] i_cmd_nresp,
  output logic       o_cmd_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_write,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic       o_resp_valid,
  output logic [7:0] o_resp_byte,
  output logic       o_done,
  output logic [1:0] o_err_code,
  output logic       o_stream_valid,
  output logic [7:0] o_stream_byte
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RETRY   = 2'b10;
  localparam logic [1:0] ERR_DEVICE  = 2'b11;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_RESP, FINISH} state_t;

  state_t        r_state, w_state_next;
  logic [7:0]    r_tx_data, w_tx_data_next;
  logic [1:0]    r_remaining, w_remaining_next;
  logic [RW-1:0] r_retry, w_retry_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [1:0]    r_err, w_err_next;
  logic          r_tx_write;
  logic          r_resp_valid, w_resp_valid_next;
  logic [7:0]    r_resp_byte, w_resp_byte_next;
  logic          r_done;
  logic          r_stream_valid, w_stream_valid_next;
  logic [7:0]    r_stream_byte, w_stream_byte_next;
  logic          w_expired;
  logic          w_accept;

  // Not ready during the done pulse, so a new command cannot race the previous result.
  assign o_cmd_ready = i_rst_n && (r_state == IDLE) && !r_done;
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_expired   = (r_timer <= TW'(1));

  always_comb begin
    w_state_next        = r_state;
    w_tx_data_next      = r_tx_data;
    w_remaining_next    = r_remaining;
    w_retry_next        = r_retry;
    w_timer_next        = r_timer;
    w_err_next          = r_err;
    w_resp_valid_next   = 1'b0;
    w_resp_byte_next    = r_resp_byte;
    w_stream_valid_next = 1'b0;
    w_stream_byte_next  = r_stream_byte;
    case (r_state)
      IDLE: begin
        if (i_rx_done) begin
          w_stream_valid_next = 1'b1;
          w_stream_byte_next  = i_rx_data;
        end
        if (w_accept) begin
          w_tx_data_next   = i_cmd_byte;
          w_remaining_next = i_cmd_nresp;
          w_retry_next     = '0;
          w_err_next       = ERR_OK;
          w_state_next     = SEND;
        end
      end
      SEND: begin
        w_timer_next = TIMER_LOAD;
        w_state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i_rx_done && i_rx_data == 8'hFA) begin
          if (r_remaining == 2'd0) begin
            w_err_next   = ERR_OK;
            w_state_next = FINISH;
          end else begin
            w_timer_next = TIMER_LOAD;
            w_state_next = WAIT_RESP;
          end
        end else if (i_rx_done && i_rx_data == 8'hFE) begin
          if (r_retry < RETRY_MAX) begin
            w_retry_next = r_retry + RW'(1);
            w_state_next = SEND;
          end else begin
            w_err_next   = ERR_RETRY;
            w_state_next = FINISH;
          end
        end else if (i_rx_done && i_rx_data == 8'hFC) begin
          w_err_next   = ERR_DEVICE;
          w_state_next = FINISH;
        end else if (w_expired) begin
          // Unrecognised bytes are ignored and do not hold off the timeout.
          w_err_next   = ERR_TIMEOUT;
          w_state_next = FINISH;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      WAIT_RESP: begin
        if (i_rx_done) begin
          w_resp_valid_next = 1'b1;
          w_resp_byte_next  = i_rx_data;
          w_remaining_next  = r_remaining - 2'd1;
          w_timer_next      = TIMER_LOAD;
          if (r_remaining == 2'd1) begin
            w_err_next   = ERR_OK;
            w_state_next = FINISH;
          end
        end else if (w_expired) begin
          w_err_next   = ERR_TIMEOUT;
          w_state_next = FINISH;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      FINISH: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_tx_data      <= '0;
      r_remaining    <= '0;
      r_retry        <= '0;
      r_timer        <= '0;
      r_err          <= ERR_OK;
      r_tx_write     <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_byte    <= '0;
      r_done         <= 1'b0;
      r_stream_valid <= 1'b0;
      r_stream_byte  <= '0;
    end else begin
      r_state        <= w_state_next;
      r_tx_data      <= w_tx_data_next;
      r_remaining    <= w_remaining_next;
      r_retry        <= w_retry_next;
      r_timer        <= w_timer_next;
      r_err          <= w_err_next;
      r_tx_write     <= (w_state_next == SEND);
      r_resp_valid   <= w_resp_valid_next;
      r_resp_byte    <= w_resp_byte_next;
      r_done         <= (r_state == FINISH);
      r_stream_valid <= w_stream_valid_next;
      r_stream_byte  <= w_stream_byte_next;
    end
  end

  assign o_tx_data      = r_tx_data;
  assign o_tx_write     = r_tx_write;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_byte    = r_resp_byte;
  assign o_done         = r_done;
  assign o_err_code     = r_err;
  assign o_stream_valid = r_stream_valid;
  assign o_stream_byte  = r_stream_byte;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Scoreboard bench for ps2_cmd_sequencer: expected output events are queued as the
// device side is driven and matched against every DUT pulse.
module tb_ps2_cmd_sequencer;

  localparam int T  = 100;
  localparam int MR = 3;
  localparam logic [7:0] K_TX   = 8'h01;
  localparam logic [7:0] K_RESP = 8'h02;
  localparam logic [7:0] K_DONE = 8'h03;
  localparam logic [7:0] K_STRM = 8'h04;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic [1:0] cmd_nresp;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       tx_write;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       resp_valid;
  logic [7:0] resp_byte;
  logic       done;
  logic [1:0] err_code;
  logic       stream_valid;
  logic [7:0] stream_byte;

  logic [15:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  ps2_cmd_sequencer #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .i_cmd_byte(cmd_byte), .i_cmd_nresp(cmd_nresp),
    .o_cmd_ready(cmd_ready), .o_tx_data(tx_data), .o_tx_write(tx_write),
    .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_resp_valid(resp_valid), .o_resp_byte(resp_byte),
    .o_done(done), .o_err_code(err_code),
    .o_stream_valid(stream_valid), .o_stream_byte(stream_byte)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic [7:0] kind, input logic [7:0] data);
    exp_q.push_back({kind, data});
  endtask

  // An output pulse with nothing queued is compared against FFFF and so always reports.
  task automatic pop_check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (exp_q.size() == 0) e = 16'hFFFF;
    else e = exp_q.pop_front();
    $display("txn %-6s kind=%h data=%h at %0t", tag, obs[15:8], obs[7:0], $time);
    check(tag, {16'h0, obs}, {16'h0, e});
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (tx_write)     pop_check("tx",     {K_TX, tx_data});
      if (resp_valid)   pop_check("resp",   {K_RESP, resp_byte});
      if (done)         pop_check("done",   {K_DONE, 6'd0, err_code});
      if (stream_valid) pop_check("stream", {K_STRM, stream_byte});
    end
  end

  task automatic send_cmd(input logic [7:0] b, input logic [1:0] n);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    cmd_nresp = n;
    expect_ev(K_TX, b);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic dev_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Counts falling edges until done is seen; checks cmd_ready drops then returns.
  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_rdy_at_done"}, {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_rdy_after"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_byte = '0; cmd_nresp = '0;
    rx_data = '0; rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_ctl", {26'd0, tx_write, resp_valid, done, stream_valid, err_code}, 32'd0);
    check("rst_data", {8'd0, tx_data, resp_byte, stream_byte}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_post_rst", {31'd0, cmd_ready}, 32'd1);

    // Plain ACK after 50 cycles, no response bytes.
    send_cmd(8'hF4, 2'd0);
    repeat (49) @(negedge clk);
    expect_ev(K_DONE, 8'h00);
    dev_byte(8'hFA);
    wait_done("ack_only", 1);
    check("tx_data_held", {24'd0, tx_data}, 32'h0000_00F4);

    // Reset command with two response bytes; done two cycles after the last byte.
    send_cmd(8'hFF, 2'd2);
    repeat (5) @(negedge clk);
    dev_byte(8'hFA);
    repeat (3) @(negedge clk);
    expect_ev(K_RESP, 8'hAA);
    dev_byte(8'hAA);
    repeat (3) @(negedge clk);
    expect_ev(K_RESP, 8'h00);
    expect_ev(K_DONE, 8'h00);
    dev_byte(8'h00);
    wait_done("resp2", 1);

    // Resend four times: first send plus three retries, then error 10.
    send_cmd(8'hED, 2'd0);
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clk);
      if (i < MR) expect_ev(K_TX, 8'hED);
      else expect_ev(K_DONE, 8'h02);
      dev_byte(8'hFE);
    end
    wait_done("retry", 1);

    // Silent device: timer loaded at the edge ending the tx_write cycle, expires
    // T edges later, done registered one edge after that.
    send_cmd(8'hF2, 2'd0);
    expect_ev(K_DONE, 8'h01);
    wait_done("timeout", T + 2);

    // ACK sampled on the very edge the timer would expire: the byte wins.
    send_cmd(8'hF2, 2'd0);
    repeat (T - 1) @(negedge clk);
    expect_ev(K_DONE, 8'h00);
    dev_byte(8'hFA);
    wait_done("ack_at_expiry", 1);

    // Unsolicited byte in IDLE goes to the stream port.
    repeat (3) @(negedge clk);
    expect_ev(K_STRM, 8'h1C);
    dev_byte(8'h1C);
    check("stream_ready", {31'd0, cmd_ready}, 32'd1);

    // Unrelated byte while awaiting ACK is dropped, then device error 0xFC.
    send_cmd(8'hF5, 2'd1);
    repeat (3) @(negedge clk);
    dev_byte(8'h55);
    repeat (2) @(negedge clk);
    expect_ev(K_DONE, 8'h03);
    dev_byte(8'hFC);
    wait_done("dev_err", 1);

    // Reset in WAIT_RESP, right while a response pulse is showing.
    send_cmd(8'hFF, 2'd3);
    repeat (3) @(negedge clk);
    dev_byte(8'hFA);
    repeat (2) @(negedge clk);
    expect_ev(K_RESP, 8'hAA);
    dev_byte(8'hAA);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctl", {25'd0, cmd_ready, tx_write, resp_valid, done, stream_valid, err_code}, 32'd0);
    check("midrst_data", {8'd0, tx_data, resp_byte, stream_byte}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (30) @(negedge clk);
    check("midrst_err", {30'd0, err_code}, 32'd0);

    check("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
